// File: rtl/div_ctrl_if.sv
// Controller-to-divider-core link: launch/abort pulses and latched operands out,
// completion pulse and raw quotient/remainder back.
interface div_ctrl_if;
    logic        div_start;
    logic        div_abort;
    logic        div_sign;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;

    modport master (
        output div_start, div_abort, div_sign, div_dividend, div_divisor,
        input  div_done, div_q, div_r
    );

    modport slave (
        input  div_start, div_abort, div_sign, div_dividend, div_divisor,
        output div_done, div_q, div_r
    );
endinterface

// File: rtl/div_ctrl.sv
// Sequences the multi-cycle divider for DIV/DIVU in EX: launches the core, stalls the
// front end until HI/LO is written, aborts on flush, bypasses zero divisors, watchdogs the core.
module div_ctrl #(
    parameter int DIV_CYCLES = 34,
    parameter int CNT_W      = 6
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ex_div_req,
    input  logic         ex_div_sign,
    input  logic [31:0]  ex_rdata1,
    input  logic [31:0]  ex_rdata2,
    input  logic         int_flush,
    input  logic         exe_stall,
    output logic         int_div_stall,
    output logic [1:0]   hilo_we,
    output logic [31:0]  hi_wdata,
    output logic [31:0]  lo_wdata,
    output logic         div_busy,
    output logic         div_timeout,
    div_ctrl_if.master   core
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic              start_q, start_d;
    logic              abort_q, abort_d;
    logic              sign_q, sign_d;
    logic [31:0]       dividend_q, dividend_d;
    logic [31:0]       divisor_q, divisor_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              timeout_q, timeout_d;
    logic              stall_s;
    logic [1:0]        hilo_we_s;

    // Next-state, datapath loads and the combinational stall/write-enable outputs.
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        start_d    = 1'b0;
        abort_d    = 1'b0;
        sign_d     = sign_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        timeout_d  = timeout_q;
        stall_s    = 1'b0;
        hilo_we_s  = 2'b00;

        case (state_q)
            IDLE: begin
                // Stall in the trigger cycle itself so ID/EX keeps the instruction.
                if (ex_div_req && !int_flush) begin
                    stall_s = 1'b1;
                    if (ex_rdata2 != 32'd0) begin
                        sign_d     = ex_div_sign;
                        dividend_d = ex_rdata1;
                        divisor_d  = ex_rdata2;
                        start_d    = 1'b1;
                        counter_d  = {CNT_W{1'b0}};
                        state_d    = RUN;
                    end else begin
                        hi_d    = ex_rdata1;
                        lo_d    = 32'hFFFF_FFFF;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                stall_s = 1'b1;
                if (counter_q != CNT_MAX) begin
                    counter_d = counter_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    counter_d = counter_q;
                end
                // Flush wins even over a same-cycle completion.
                if (int_flush) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (core.div_done) begin
                    hi_d    = core.div_r;
                    lo_d    = core.div_q;
                    state_d = DONE;
                end else if (counter_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    abort_d   = 1'b1;
                    hi_d      = 32'd0;
                    lo_d      = 32'd0;
                    state_d   = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (int_flush) begin
                    state_d = IDLE;
                end else begin
                    hilo_we_s = 2'b11;
                    state_d   = exe_stall ? HOLD : IDLE;
                end
            end
            HOLD: begin
                // The finished instruction is still in EX; its request must not relaunch.
                if (!exe_stall || int_flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            counter_q  <= {CNT_W{1'b0}};
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            sign_q     <= 1'b0;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            start_q    <= start_d;
            abort_q    <= abort_d;
            sign_q     <= sign_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            timeout_q  <= timeout_d;
        end
    end

    assign int_div_stall     = stall_s;
    assign hilo_we           = hilo_we_s;
    assign hi_wdata          = hi_q;
    assign lo_wdata          = lo_q;
    assign div_busy          = (state_q == RUN);
    assign div_timeout       = timeout_q;
    assign core.div_start    = start_q;
    assign core.div_abort    = abort_q;
    assign core.div_sign     = sign_q;
    assign core.div_dividend = dividend_q;
    assign core.div_divisor  = divisor_q;

endmodule
